// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache
// with true-LRU (per-way age counters), flush sequence and hit/miss stats.
// Ports:
//   clk, reset (async active-low)
//   in_tlb_hit, in_read_en, in_write_en, in_bypass_found, in_addr,
//   in_write_data, in_funct3, in_flush       - MEM-stage request side
//   in_mem_read_data, in_mem_ready           - line-wide memory response
//   out_read_data, out_hit, out_busy         - combinational lookup results
//   out_flush_done, out_mem_read_en, out_mem_write_en, out_mem_addr,
//   out_mem_write_data                       - registered memory side
//   out_hit_count, out_miss_count            - saturating statistics
module dcache_nway #(
  parameter int unsigned NUM_SETS        = 4,
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned CACHE_LINE_SIZE = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_tlb_hit,
  input  logic                       in_read_en,
  input  logic                       in_write_en,
  input  logic                       in_bypass_found,
  input  logic [31:0]                in_addr,
  input  logic [31:0]                in_write_data,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_flush,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [31:0]                out_read_data,
  output logic                       out_hit,
  output logic                       out_busy,
  output logic                       out_flush_done,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [31:0]                out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  output logic [31:0]                out_hit_count,
  output logic [31:0]                out_miss_count
);
  localparam int unsigned OFF  = $clog2(CACHE_LINE_SIZE / 8);
  localparam int unsigned IDX  = $clog2(NUM_SETS);
  localparam int unsigned TAG  = 32 - OFF - IDX;
  localparam int unsigned WAYW = $clog2(NUM_WAYS);
  localparam int unsigned WIDX = OFF - 2;
  localparam int unsigned EW   = IDX + WAYW;
  localparam int unsigned ENT  = NUM_SETS * NUM_WAYS;
  localparam int unsigned PTRW = EW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH_SCAN, S_FLUSH_WB} state_t;

  // Storage is flat, indexed by {set, way}
  logic [ENT-1:0]             valid_q, dirty_q;
  logic [TAG-1:0]             tag_q  [ENT];
  logic [CACHE_LINE_SIZE-1:0] line_q [ENT];
  logic [WAYW-1:0]            age_q  [ENT];

  state_t state_q, state_d;
  logic [PTRW-1:0] fptr_q, fptr_d;
  logic [31:0]     lat_addr_q, lat_wd_q;
  logic [1:0]      lat_f3_q;
  logic [WAYW-1:0] lat_way_q;
  logic            lat_store_q;

  logic [IDX-1:0]  cur_set, lat_set, fset;
  logic [TAG-1:0]  cur_tag, lat_tag;
  logic [WIDX-1:0] cur_word, lat_word;
  logic [WAYW-1:0] fway, hit_way, victim_c;
  logic [EW-1:0]   fent;
  logic            active, hit_any, miss_go, hit_evt, victim_found;
  logic            wb_done, refill_done, fwb_done;
  logic            rd_en_d, wr_en_d, fdone_d;
  logic [31:0]     addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_d;

  assign cur_set  = in_addr[OFF +: IDX];
  assign cur_tag  = in_addr[31 -: TAG];
  assign cur_word = in_addr[2 +: WIDX];
  assign lat_set  = lat_addr_q[OFF +: IDX];
  assign lat_tag  = lat_addr_q[31 -: TAG];
  assign lat_word = lat_addr_q[2 +: WIDX];
  assign fent     = fptr_q[EW-1:0];
  assign fset     = fptr_q[WAYW +: IDX];
  assign fway     = fptr_q[WAYW-1:0];

  // Byte-enabled store merge of one 32-bit word into a line
  function automatic logic [CACHE_LINE_SIZE-1:0] merge_line(
    input logic [CACHE_LINE_SIZE-1:0] line, input logic [WIDX-1:0] widx,
    input logic [1:0] size, input logic [1:0] lo, input logic [31:0] wd);
    logic [3:0]  be;
    logic [31:0] aligned, word;
    logic [CACHE_LINE_SIZE-1:0] res;
    case (size)
      2'b00:   begin be = 4'b0001 << lo;                 aligned = {4{wd[7:0]}};  end
      2'b01:   begin be = lo[1] ? 4'b1100 : 4'b0011;     aligned = {2{wd[15:0]}}; end
      default: begin be = 4'b1111;                       aligned = wd;            end
    endcase
    res  = line;
    word = line[32'(widx) * 32 +: 32];
    for (int b = 0; b < 4; b++)
      if (be[b]) word[b*8 +: 8] = aligned[b*8 +: 8];
    res[32'(widx) * 32 +: 32] = word;
    return res;
  endfunction

  // Lookup: hit way and victim for the requested set
  always_comb begin
    hit_any      = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim_c     = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit_any && valid_q[{cur_set, WAYW'(w)}] && tag_q[{cur_set, WAYW'(w)}] == cur_tag) begin
        hit_any = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!victim_found && !valid_q[{cur_set, WAYW'(w)}]) begin
        victim_found = 1'b1;
        victim_c     = WAYW'(w);
      end
    end
    if (!victim_found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[{cur_set, WAYW'(w)}] == WAYW'(NUM_WAYS - 1)) victim_c = WAYW'(w);
  end

  // Reset gates the lookup so every output reads zero while held
  assign active   = reset && (state_q == S_IDLE) && ((in_read_en && !in_bypass_found) || in_write_en);
  assign hit_evt  = active && hit_any;
  assign miss_go  = active && in_tlb_hit && !hit_any;
  assign out_hit  = hit_evt;
  assign out_busy = miss_go || (state_q != S_IDLE);

  // Load extraction with sign/zero extension
  always_comb begin
    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    word   = line_q[{cur_set, hit_way}][32'(cur_word) * 32 +: 32];
    byte_v = 8'(word >> {in_addr[1:0], 3'b000});
    half_v = in_addr[1] ? word[31:16] : word[15:0];
    case (in_funct3[1:0])
      2'b00:   out_read_data = in_funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   out_read_data = in_funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: out_read_data = word;
    endcase
    if (!hit_evt) out_read_data = '0;
  end

  // Next state and next values of the registered memory-side outputs
  always_comb begin
    state_d     = state_q;
    fptr_d      = fptr_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    fdone_d     = 1'b0;
    addr_d      = out_mem_addr;
    wdata_d     = out_mem_write_data;
    wb_done     = 1'b0;
    refill_done = 1'b0;
    fwb_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_go) begin
          if (valid_q[{cur_set, victim_c}] && dirty_q[{cur_set, victim_c}]) begin
            state_d = S_WRITEBACK;
            wr_en_d = 1'b1;
            addr_d  = {tag_q[{cur_set, victim_c}], cur_set, OFF'(0)};
            wdata_d = line_q[{cur_set, victim_c}];
          end else begin
            state_d = S_REFILL;
            rd_en_d = 1'b1;
            addr_d  = {cur_tag, cur_set, OFF'(0)};
          end
        end else if (in_flush) begin
          state_d = S_FLUSH_SCAN;
          fptr_d  = '0;
        end
      end
      S_WRITEBACK: begin
        if (in_mem_ready) begin
          // Read enable is held low for one gap cycle after the write
          wb_done = 1'b1;
          state_d = S_REFILL;
          addr_d  = {lat_tag, lat_set, OFF'(0)};
          wdata_d = '0;
        end else begin
          wr_en_d = 1'b1;
        end
      end
      S_REFILL: begin
        rd_en_d = 1'b1;
        if (in_mem_ready && out_mem_read_en) begin
          refill_done = 1'b1;
          rd_en_d     = 1'b0;
          state_d     = S_IDLE;
          addr_d      = '0;
        end
      end
      S_FLUSH_SCAN: begin
        if (fptr_q[PTRW-1]) begin
          state_d = S_IDLE;
          fdone_d = 1'b1;
        end else if (valid_q[fent] && dirty_q[fent]) begin
          state_d = S_FLUSH_WB;
          wr_en_d = 1'b1;
          addr_d  = {tag_q[fent], fset, OFF'(0)};
          wdata_d = line_q[fent];
        end else if (fptr_q == PTRW'(ENT - 1)) begin
          state_d = S_IDLE;
          fdone_d = 1'b1;
        end else begin
          fptr_d = fptr_q + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        if (in_mem_ready) begin
          fwb_done = 1'b1;
          fptr_d   = fptr_q + 1'b1;
          state_d  = S_FLUSH_SCAN;
          addr_d   = '0;
          wdata_d  = '0;
        end else begin
          wr_en_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      fptr_q             <= '0;
      out_mem_read_en    <= 1'b0;
      out_mem_write_en   <= 1'b0;
      out_mem_addr       <= '0;
      out_mem_write_data <= '0;
      out_flush_done     <= 1'b0;
    end else begin
      state_q            <= state_d;
      fptr_q             <= fptr_d;
      out_mem_read_en    <= rd_en_d;
      out_mem_write_en   <= wr_en_d;
      out_mem_addr       <= addr_d;
      out_mem_write_data <= wdata_d;
      out_flush_done     <= fdone_d;
    end
  end

  // Miss context latched for the duration of the transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr_q  <= '0;
      lat_wd_q    <= '0;
      lat_f3_q    <= '0;
      lat_way_q   <= '0;
      lat_store_q <= 1'b0;
    end else if (miss_go) begin
      lat_addr_q  <= in_addr;
      lat_wd_q    <= in_write_data;
      lat_f3_q    <= in_funct3[1:0];
      lat_way_q   <= victim_c;
      lat_store_q <= in_write_en;
    end
  end

  // Valid/dirty/age metadata and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      out_hit_count  <= '0;
      out_miss_count <= '0;
      for (int e = 0; e < ENT; e++) age_q[e] <= WAYW'(e % NUM_WAYS);
    end else begin
      if (hit_evt || refill_done) begin
        logic [IDX-1:0]  ls;
        logic [WAYW-1:0] lw;
        ls = hit_evt ? cur_set : lat_set;
        lw = hit_evt ? hit_way : lat_way_q;
        for (int w = 0; w < NUM_WAYS; w++)
          if (age_q[{ls, WAYW'(w)}] < age_q[{ls, lw}])
            age_q[{ls, WAYW'(w)}] <= WAYW'(age_q[{ls, WAYW'(w)}] + 1'b1);
        age_q[{ls, lw}] <= '0;
      end
      if (hit_evt && in_write_en) dirty_q[{cur_set, hit_way}] <= 1'b1;
      if (wb_done)                dirty_q[{lat_set, lat_way_q}] <= 1'b0;
      if (fwb_done)               dirty_q[fent] <= 1'b0;
      if (refill_done) begin
        valid_q[{lat_set, lat_way_q}] <= 1'b1;
        dirty_q[{lat_set, lat_way_q}] <= lat_store_q;
      end
      if (hit_evt && out_hit_count != '1)  out_hit_count  <= out_hit_count + 1'b1;
      if (miss_go && out_miss_count != '1) out_miss_count <= out_miss_count + 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (hit_evt && in_write_en)
      line_q[{cur_set, hit_way}] <= merge_line(line_q[{cur_set, hit_way}], cur_word,
                                               in_funct3[1:0], in_addr[1:0], in_write_data);
    if (refill_done) begin
      tag_q[{lat_set, lat_way_q}]  <= lat_tag;
      line_q[{lat_set, lat_way_q}] <= lat_store_q
        ? merge_line(in_mem_read_data, lat_word, lat_f3_q, lat_addr_q[1:0], lat_wd_q)
        : in_mem_read_data;
    end
  end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache for the MEM stage. It is the successor to the fixed 2-set/2-way cache and adds several capabilities: configurable sets, ways and line width; true-LRU replacement via per-way age counters; unsigned loads; an explicit flush sequence; and hit/miss statistics. It sits between the MEM stage (with TLB-hit and bypass qualifiers) and the line-wide main-memory interface.

## Interface
- NUM_SETS, 4: number of sets; power of two, ≥2.
- NUM_WAYS, 4: ways per set; power of two, ≥2.
- CACHE_LINE_SIZE, 128: line width in bits; power of two, ≥64.
- clk in 1: single clock; all state updates on the rising edge.
- reset in 1: asynchronous, active-low.
- in_tlb_hit in 1: translation valid. When low, the access is never a miss stall.
- in_read_en, in_write_en in 1 each: load/store request. These are mutually exclusive.
- in_bypass_found in 1: a store-buffer bypass supplies the load data, so the load is ignored.
- in_addr in 32: physical byte address.
- in_write_data in 32: store data, LSB-aligned.
- in_funct3 in 3: access type. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- in_flush in 1: single-cycle pulse requesting write-back of all dirty lines.
- in_mem_read_data in CACHE_LINE_SIZE: refill line.
- in_mem_ready in 1: one-cycle pulse completing the current memory transaction.
- out_read_data out 32: extended load data.
- out_hit out 1: lookup hit.
- out_busy out 1: stall request to the pipeline.
- out_flush_done out 1: one-cycle pulse.
- out_mem_read_en, out_mem_write_en out 1 each.
- out_mem_addr out 32: line-aligned address.
- out_mem_write_data out CACHE_LINE_SIZE: victim line.
- out_hit_count, out_miss_count out 32 each: saturating statistics counters.

## Operation
- Address decomposition:
  - OFF = log2(CACHE_LINE_SIZE/8); IDX = log2(NUM_SETS); TAG = 32−OFF−IDX.
  - tag = addr[31:OFF+IDX], set = addr[OFF+IDX−1:OFF], word = addr[OFF−1:2].
  - B uses addr[1:0]; H uses addr[1] only; W ignores addr[1:0].
- Lookup (combinational, IDLE state only):
  - A request is active when (in_read_en && !in_bypass_found) || in_write_en.
  - out_hit = active && any way valid with matching tag.
  - Loads:
    - B/H are sign-extended; BU/HU are zero-extended.
    - out_read_data = 0 when not a hit.
  - out_busy = active && in_tlb_hit && !out_hit, OR state ≠ IDLE.
- Store hit: on the clock edge, merge the byte-enabled data into the line, set dirty, and update LRU.
- LRU:
  - Each way holds a log2(NUM_WAYS)-bit age. Reset value of age[w] = w in every set.
  - On any hit or fill of way k, every way whose age is below age[k] increments, then age[k] = 0.
- Victim selection: the lowest-index invalid way; otherwise the way with age NUM_WAYS−1. The victim is latched on the miss.
- States:
  - IDLE:
    - On a miss with in_tlb_hit, latch addr, set, tag, victim, store data and funct3.
    - Go to WRITEBACK if the victim is valid and dirty, else to REFILL.
    - Otherwise, in_flush goes to FLUSH_SCAN with a scan pointer of 0.
  - WRITEBACK:
    - Drive out_mem_write_en = 1, out_mem_addr = {victim tag, set, OFF zeros}, out_mem_write_data = victim line.
    - On in_mem_ready: clear dirty, go to REFILL.
  - REFILL:
    - Drive out_mem_read_en = 1, out_mem_addr = {tag, set, OFF zeros}.
    - On in_mem_ready:
      - Write the line.
      - If the latched access was a store, merge the store data and set dirty; otherwise clear dirty.
      - Set valid, write the tag, update LRU, return to IDLE.
    - The pipeline holds its request, so the next cycle hits.
  - FLUSH_SCAN:
    - Walk the (set, way) pointer one entry per cycle.
    - A dirty, valid entry goes to FLUSH_WB.
    - After the last entry, pulse out_flush_done and go to IDLE.
  - FLUSH_WB: write the line back as in WRITEBACK. On in_mem_ready, clear dirty, advance the pointer and return to FLUSH_SCAN. Lines stay valid.
- Statistics:
  - out_hit_count increments once per hitting access, sampled on edges in IDLE with the request active and no stall.
  - out_miss_count increments once per IDLE→WRITEBACK/REFILL transition.
  - Both saturate at 0xFFFFFFFF.

## Timing
- Reset (async assert, sync release):
  - valid, dirty and statistics are cleared to 0; ages are set as above; state = IDLE.
  - out_mem_read_en = out_mem_write_en = 0, out_mem_addr = 0, out_mem_write_data = 0, out_flush_done = 0.
  - Reset mid-transaction aborts it with no line update.
- Hit latency: 0 cycles. Data and out_hit are valid in the same cycle; stores commit on that edge.
- Clean miss: busy from the request cycle through the in_mem_ready cycle. The read enable rises on the edge after the request and falls on the edge that samples in_mem_ready.
- Dirty miss: the write transaction completes fully before the read enable rises, with exactly one cycle between ready and read enable.
- Memory enables are registered, stay stable until in_mem_ready, and are never high simultaneously.
- in_mem_ready outside WRITEBACK/REFILL/FLUSH_WB is ignored.
- Edge cases:
  - in_flush while a miss is pending or out_busy is high is dropped.
  - A flush with no dirty lines completes in NUM_SETS·NUM_WAYS+1 cycles.
  - in_tlb_hit = 0 on a miss: no state change, no busy, no counter update.

## Test plan
- Reset, then LW 0x100 (miss, mem returns line 0x…DDCCBBAA_44332211) → busy until ready, read enable at 0x100; the following cycle out_hit = 1 and data = 0x44332211.
- SB 0x80 on 0x101 (cached line), then LB 0x101 → 0xFFFFFF80; LBU → 0x00000080. The line is dirty.
- NUM_WAYS = 4: fill 4 lines in one set, touch ways 0, 1, 2, then miss → way 3 evicted. If dirty: write at the victim address with its data, one idle cycle, then read.
- Dirty lines in set 0 way 1 and set 3 way 2, then pulse in_flush → exactly two writes in scan order, out_flush_done pulse, lines remain valid and clean.
- Miss with in_tlb_hit = 0 → out_busy = 0, no memory request, out_miss_count unchanged. Load with in_bypass_found = 1 → no lookup or count.
- Assert reset during REFILL before ready → all outputs 0 immediately; a later LW of the same address misses again.
